// File: rtl/mem_subword_ctrl_if.sv
// Pipeline-side and RAM-side signals of the sub-word memory controller.
// The master side is the pipeline together with the word-only RAM; the slave side is the controller.
interface mem_subword_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              memEn;
  logic [2:0]        memOp;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWtData;
  logic [DATA_W-1:0] memRdData;
  logic              stallReq;
  logic              excAddr;
  logic              ramCe;
  logic              ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramWtData;
  logic [DATA_W-1:0] ramRdData;

  modport master (
    output memEn, memOp, memAddr, memWtData, ramRdData,
    input  memRdData, stallReq, excAddr, ramCe, ramWe, ramAddr, ramWtData
  );

  modport slave (
    input  memEn, memOp, memAddr, memWtData, ramRdData,
    output memRdData, stallReq, excAddr, ramCe, ramWe, ramAddr, ramWtData
  );
endinterface

// File: rtl/mem_subword_ctrl.sv
// Byte/halfword load-store adapter for a big-endian word-only RAM; sub-word stores use read-modify-write.
// Optional macro MEM_ALIGN_CHECK_EN enables misaligned-access detection on excAddr.
module mem_subword_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_subword_ctrl_if.slave   bus
);
  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  typedef enum logic [0:0] {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

  state_t            r_state, w_state_next;
  logic [DATA_W-1:0] r_merge, w_merge_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;

  logic              w_is_load, w_is_sw, w_is_sub, w_mis, w_go;
  logic [ADDR_W-1:0] w_word_addr;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load_val;
  logic [DATA_W-1:0] w_merge;

  assign w_is_load   = (bus.memOp <= OP_LHU);
  assign w_is_sw     = (bus.memOp == OP_SW);
  assign w_is_sub    = (bus.memOp == OP_SB) || (bus.memOp == OP_SH);
  assign w_word_addr = {bus.memAddr[ADDR_W-1:2], 2'b00};

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    w_mis = 1'b0;
    case (bus.memOp)
      OP_LW, OP_SW:         w_mis = |bus.memAddr[1:0];
      OP_LH, OP_LHU, OP_SH: w_mis = bus.memAddr[0];
      default:              w_mis = 1'b0;
    endcase
  end
`else
  assign w_mis = 1'b0;
`endif

  assign w_go        = bus.memEn && !w_mis;
  assign bus.excAddr = rst && bus.memEn && w_mis && (r_state == IDLE);

  // Big-endian lanes: byte offset 0 is the most significant byte.
  always_comb begin
    w_byte = 8'h00;
    case (bus.memAddr[1:0])
      2'd0:    w_byte = bus.ramRdData[31:24];
      2'd1:    w_byte = bus.ramRdData[23:16];
      2'd2:    w_byte = bus.ramRdData[15:8];
      default: w_byte = bus.ramRdData[7:0];
    endcase
  end

  assign w_half = bus.memAddr[1] ? bus.ramRdData[15:0] : bus.ramRdData[31:16];

  always_comb begin
    w_load_val = '0;
    case (bus.memOp)
      OP_LW:   w_load_val = bus.ramRdData;
      OP_LB:   w_load_val = {{(DATA_W-8){w_byte[7]}}, w_byte};
      OP_LBU:  w_load_val = {{(DATA_W-8){1'b0}}, w_byte};
      OP_LH:   w_load_val = {{(DATA_W-16){w_half[15]}}, w_half};
      OP_LHU:  w_load_val = {{(DATA_W-16){1'b0}}, w_half};
      default: w_load_val = '0;
    endcase
  end

  // Merge word feeds only the latch, never a RAM-side output, so no loop through the RAM read path.
  always_comb begin
    w_merge = bus.ramRdData;
    if (bus.memOp == OP_SB) begin
      case (bus.memAddr[1:0])
        2'd0:    w_merge[31:24] = bus.memWtData[7:0];
        2'd1:    w_merge[23:16] = bus.memWtData[7:0];
        2'd2:    w_merge[15:8]  = bus.memWtData[7:0];
        default: w_merge[7:0]   = bus.memWtData[7:0];
      endcase
    end else if (bus.memAddr[1]) begin
      w_merge[15:0] = bus.memWtData[15:0];
    end else begin
      w_merge[31:16] = bus.memWtData[15:0];
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_merge_next  = r_merge;
    w_addr_next   = r_addr;
    bus.ramCe     = 1'b0;
    bus.ramWe     = 1'b0;
    bus.ramAddr   = '0;
    bus.ramWtData = '0;
    bus.stallReq  = 1'b0;
    bus.memRdData = '0;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          bus.ramCe   = 1'b1;
          bus.ramAddr = w_word_addr;
          if (w_is_load) begin
            bus.memRdData = w_load_val;
          end else if (w_is_sw) begin
            bus.ramWe     = 1'b1;
            bus.ramWtData = bus.memWtData;
          end else if (w_is_sub) begin
            bus.stallReq = 1'b1;
            w_merge_next = w_merge;
            w_addr_next  = w_word_addr;
            w_state_next = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        bus.ramCe     = 1'b1;
        bus.ramWe     = 1'b1;
        bus.ramAddr   = r_addr;
        bus.ramWtData = r_merge;
        w_state_next  = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    // Asserting reset silences the RAM port at once, which also kills a pending RMW write.
    if (!rst) begin
      bus.ramCe     = 1'b0;
      bus.ramWe     = 1'b0;
      bus.ramAddr   = '0;
      bus.ramWtData = '0;
      bus.stallReq  = 1'b0;
      bus.memRdData = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_merge <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      r_merge <= w_merge_next;
      r_addr  <= w_addr_next;
    end
  end
endmodule

// File: tb/tb_mem_subword_ctrl.sv
// Scoreboard bench for mem_subword_ctrl: a byte-addressed big-endian model predicts loads and RAM writes,
// a negedge monitor compares every load result and every RAM write the controller presents.
module tb_mem_subword_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_subword_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_subword_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Word-only RAM: combinational read, write on posedge.
  logic [31:0] ram [0:63];
  assign bus.ramRdData = ram[bus.ramAddr[7:2]];
  always @(posedge clk) if (bus.ramCe && bus.ramWe) ram[bus.ramAddr[7:2]] <= bus.ramWtData;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  logic [7:0]  mb [0:255];
  logic [31:0] exp_rd_q [$];
  wr_t         exp_wr_q [$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  function automatic logic mis(input logic [2:0] op, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    if (op == 3'd0 || op == 3'd5) return a[1:0] != 2'b00;
    if (op == 3'd3 || op == 3'd4 || op == 3'd7) return a[0];
    return 1'b0;
`else
    return (op == 3'd0) && (a == 32'hFFFF_FFFF);
`endif
  endfunction

  function automatic logic [31:0] mword(input int a);
    int b;
    b = a & ~3;
    return {mb[b], mb[b+1], mb[b+2], mb[b+3]};
  endfunction

  // Issue one access; holds inputs while stallReq is high and counts stall cycles.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    logic       m;
    int         ai, hb, wb, stalls, exp_st;
    logic [7:0] b8;
    logic [15:0] h16;
    m  = mis(op, a);
    ai = int'(a[7:0]);
    hb = ai & ~1;
    wb = ai & ~3;
    exp_st = (!m && (op == 3'd6 || op == 3'd7)) ? 1 : 0;
    if (!m) begin
      b8  = mb[ai];
      h16 = {mb[hb], mb[hb+1]};
      case (op)
        3'd0: exp_rd_q.push_back(mword(ai));
        3'd1: exp_rd_q.push_back({{24{b8[7]}}, b8});
        3'd2: exp_rd_q.push_back({24'h0, b8});
        3'd3: exp_rd_q.push_back({{16{h16[15]}}, h16});
        3'd4: exp_rd_q.push_back({16'h0, h16});
        3'd5: begin
          mb[wb] = d[31:24]; mb[wb+1] = d[23:16]; mb[wb+2] = d[15:8]; mb[wb+3] = d[7:0];
        end
        3'd6: mb[ai] = d[7:0];
        default: begin mb[hb] = d[15:8]; mb[hb+1] = d[7:0]; end
      endcase
      if (op >= 3'd5) exp_wr_q.push_back('{a: {a[31:2], 2'b00}, d: mword(ai)});
    end
    bus.memEn = 1'b1; bus.memOp = op; bus.memAddr = a; bus.memWtData = d;
    stalls = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("excAddr", {31'b0, bus.excAddr}, {31'b0, m});
        if (m) check("mis_ramCe", {31'b0, bus.ramCe}, 32'd0);
      end
      if (!bus.stallReq) break;
      stalls++;
      @(posedge clk); #1;
    end
    check("stall_cycles", stalls, exp_st);
    $display("txn op=%0d addr=%02h data=%08h stalls=%0d", op, a[7:0], d, stalls);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    bus.memEn = 1'b0; bus.memOp = 3'($urandom_range(0, 7)); bus.memAddr = 32'($urandom_range(0, 63));
    @(negedge clk);
    check("idle_out", {bus.ramCe, bus.ramWe, bus.stallReq, bus.excAddr, bus.memRdData[27:0]}, 32'd0);
    $display("txn idle");
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.ramCe && bus.ramWe) begin
        if (exp_wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write actual=%08h@%08h required=none", bus.ramWtData, bus.ramAddr);
        end else begin
          wr_t w;
          w = exp_wr_q.pop_front();
          check("wr_addr", bus.ramAddr, w.a);
          check("wr_data", bus.ramWtData, w.d);
        end
      end
      if (bus.memEn && bus.memOp <= 3'd4 && !mis(bus.memOp, bus.memAddr)) begin
        if (exp_rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_load actual=%08h required=none", bus.memRdData);
        end else begin
          check("load_data", bus.memRdData, exp_rd_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0;
    for (int i = 0; i < 256; i++) mb[i] = 8'h00;
    bus.memEn = 1'b1; bus.memOp = 3'd0; bus.memAddr = 32'h10; bus.memWtData = 32'h0;
    #12;
    check("reset_out", {bus.ramCe, bus.ramWe, bus.stallReq, bus.excAddr, bus.memRdData[27:0]}, 32'd0);
    check("reset_rd", bus.memRdData, 32'd0);
    @(posedge clk); #1;
    bus.memEn = 1'b0;
    rst = 1'b1;

    for (int w = 0; w < 16; w++) issue(3'd5, 32'(w * 4), $urandom);

    issue(3'd5, 32'h10, 32'h11223344);
    issue(3'd1, 32'h12, 32'h0);
    issue(3'd3, 32'h12, 32'h0);
    issue(3'd5, 32'h10, 32'h80FFFFFF);
    issue(3'd1, 32'h10, 32'h0);
    issue(3'd2, 32'h10, 32'h0);
    issue(3'd5, 32'h10, 32'h11223344);
    issue(3'd6, 32'h11, 32'h000000AA);
    issue(3'd0, 32'h10, 32'h0);
    issue(3'd5, 32'h10, 32'h11223344);
    t0 = $time;
    issue(3'd7, 32'h12, 32'h0000BEEF);
    issue(3'd6, 32'h10, 32'h00000099);
    check("shsb_cycles", 32'(($time - t0) / 10), 32'd4);
    issue(3'd0, 32'h10, 32'h0);
    check("shsb_word", mword(16), 32'h9922BEEF);
    issue(3'd5, 32'h20, 32'hDEADBEEF);
    issue(3'd0, 32'h20, 32'h0);
    idle_cycle();
    idle_cycle();

    // Reset during the write half of a sub-word store must leave the word untouched.
    issue(3'd5, 32'h10, 32'h11223344);
    bus.memEn = 1'b1; bus.memOp = 3'd6; bus.memAddr = 32'h11; bus.memWtData = 32'hAA;
    @(negedge clk);
    check("rmw_stall", {31'b0, bus.stallReq}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_out", {bus.ramCe, bus.ramWe, bus.stallReq, bus.excAddr, bus.memRdData[27:0]}, 32'd0);
    bus.memEn = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    $display("txn reset_abort");
    issue(3'd0, 32'h10, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
    issue(3'd0, 32'h11, 32'h0);
    issue(3'd7, 32'h13, 32'h1234);
`else
    issue(3'd0, 32'h13, 32'h0);
    issue(3'd4, 32'h13, 32'h0);
    issue(3'd7, 32'h13, 32'h1234);
`endif

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) idle_cycle();
      else issue(3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)), $urandom);
    end

    bus.memEn = 1'b0;
    @(negedge clk);
    check("wr_q_left", exp_wr_q.size(), 32'd0);
    check("rd_q_left", exp_rd_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_subword_ctrl.md
MEM_SUBWORD_CTRL -- requirements
Module: mem_subword_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width (fixed at 32; other values unsupported).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port memEn  input  1  pipeline memory request valid.
REQ-006 SHALL have port memOp  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 SW, 110 SB, 111 SH.
REQ-007 SHALL have port memAddr  input  ADDR_W  byte address from the EX/MEM stage.
REQ-008 SHALL have port memWtData  input  32  store data; the sub-word is in its LSBs.
REQ-009 SHALL have port memRdData  output  32  extended load result.
REQ-010 SHALL have port stallReq  output  1  pipeline hold request.
REQ-011 SHALL have port excAddr  output  1  misaligned access flag.
REQ-012 SHALL have ports ramCe/ramWe  output  1 each, ramAddr  output  ADDR_W, ramWtData  output  32, ramRdData  input  32; these connect to the word-only RAM (combinational read, write on posedge, big-endian).

Function
REQ-013 SHALL drive ramAddr = memAddr with bits [1:0] forced to 00 whenever ramCe=1.
REQ-014 SHALL use big-endian lane mapping: byte offset 0 is bits 31:24 and offset 3 is bits 7:0; halfword offset 0 is bits 31:16 and offset 2 is bits 15:0.
REQ-015 SHALL use an FSM with states IDLE and RMW_WR, and reset to IDLE.
REQ-016 Loads (LW/LB/LBU/LH/LHU), IDLE: SHALL assert ramCe=1, ramWe=0, and return memRdData combinationally in the same cycle, with zero stall.
REQ-017 SHALL sign-extend LB/LH, zero-extend LBU/LHU, and pass LW through; memRdData SHALL be 0 when no load is active.
REQ-018 SW, IDLE: SHALL assert ramCe=1, ramWe=1, and ramWtData=memWtData for one cycle, with zero stall.
REQ-019 SB/SH, IDLE: SHALL assert ramCe=1, ramWe=0, and stallReq=1 (combinational); SHALL latch the merge of ramRdData with the selected lane replaced by memWtData[7:0] or [15:0]; next state RMW_WR.
REQ-020 RMW_WR: SHALL assert ramCe=1, ramWe=1, ramWtData=the latched merge word, and stallReq=0; the next state SHALL be IDLE unconditionally, so a sub-word store costs exactly 2 cycles.
REQ-021 SHALL require the pipeline to hold memEn/memOp/memAddr/memWtData stable while stallReq=1; RMW_WR SHALL use the latched address, not the live inputs.
REQ-022 memEn=0 in IDLE: SHALL drive ramCe=0, ramWe=0, stallReq=0, and hold the state.
REQ-023 SHALL not let back-to-back sub-word stores to the same word lose data: the second read SHALL occur in the cycle after the first write edge.
REQ-024 SHALL not have any RAM-side output depend on ramRdData, so there is no combinational loop.

Reset
REQ-025 While rst=0: state=IDLE, merge register=0, ramCe=0, ramWe=0, stallReq=0, excAddr=0, memRdData=0.
REQ-026 Reset asserted in RMW_WR SHALL abort the pending write; no RAM write SHALL occur on or after that edge.

Configuration
REQ-027 Macro MEM_ALIGN_CHECK_EN: when defined, SHALL assert excAddr combinationally if LW/SW have addr[1:0]!=00 or LH/LHU/SH have addr[0]!=0; a flagged access SHALL drive ramCe=0, ramWe=0, stallReq=0, and memRdData=0, and SHALL not enter RMW_WR.
REQ-028 Without MEM_ALIGN_CHECK_EN: excAddr SHALL be tied 0, and low address bits below the access size SHALL be ignored (lane chosen by addr[1] for halfwords).

Verification
REQ-029 RAM word @0x10=0x11223344; LB 0x12 -> memRdData=0x00000033; LH 0x12 -> 0x00003344; LB 0x10 with word 0x80FFFFFF -> 0xFFFFFF80; LBU -> 0x00000080.
REQ-030 SB 0x11 data 0x000000AA onto 0x11223344 -> stallReq=1 for 1 cycle, ramWe=1 next cycle with ramWtData=0x11AA3344; readback LW 0x10=0x11AA3344.
REQ-031 SH 0x12 data 0x0000BEEF then immediately SB 0x10 data 0x99 -> final word 0x9922BEEF; 4 cycles total.
REQ-032 SW 0x20 data 0xDEADBEEF -> single-cycle write, stallReq=0 throughout, LW 0x20 returns 0xDEADBEEF.
REQ-033 SB issued, rst driven low during RMW_WR -> word unchanged (0x11223344), outputs 0 immediately.
REQ-034 With MEM_ALIGN_CHECK_EN: LW 0x11 -> excAddr=1, ramCe=0; SH 0x13 -> excAddr=1, no write, no stall.
